naf_decode: RTL
===============

Name: naf_decode

Overview:
- Inverse of the team's NAF encoder: takes a NAF digit sequence h (2 bits per digit: 01=+1, 11=-1, 00=0, 10 illegal) plus a digit count and rebuilds the 256-bit scalar k.
- Processes one digit per clock, MSB digit first, using acc = 2*acc + d.
- Sits beside the SM2 scalar path. It is used for encoder round-trip checking and for restoring a scalar from stored NAF form.

Parameters:
- KW, 256, scalar width in bits
- DW, 512, digit vector width (2*KW)
- LW, 32, width of the length input

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- h  input  DW  digit vector; digit j is at h[2j+1:2j]
- hlength  input  LW  number of valid digits n; digits 0..n-1 are used
- k  output  KW  decoded scalar, registered
- busy  output  1  high in PROC
- done  output  1  one-cycle pulse in FIN
- err  output  3  [0] illegal code 10; [1] adjacent nonzero digits; [2] length >KW or result outside [0, 2^KW)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset: state=IDLE; k=0, err=0, busy=0, done=0; all internal registers cleared.
- Reset asserted mid-operation aborts immediately. No done pulse follows; outputs return to reset values.

State machine (IDLE, PROC, FIN):
- IDLE, start=1:
  - Latch h and hlength.
  - acc<=0 (signed, KW+2 bits); idx<=hlength-1; prev_nz<=0; clear the err accumulator.
  - If hlength==0 or hlength>KW: go to FIN. For hlength>KW, set err[2].
  - Otherwise go to PROC.
- PROC, each cycle:
  - d = digit idx, mapped 00→0, 01→+1, 11→-1.
  - 10 sets err[0] and is treated as 0.
  - Nonzero d with prev_nz=1 sets err[1].
  - acc<=2*acc+d; prev_nz<=(d!=0); idx<=idx-1.
  - After consuming idx==0, go to FIN.
- FIN, single cycle:
  - done=1.
  - If acc<0 or acc>=2^KW, set err[2].
  - If any err bit is set, k<=0; else k<=acc[KW-1:0].
  - Return to IDLE.
- k and err stay registered from FIN until the next accepted start. They change only in FIN.
- start while busy or in FIN is ignored. No queuing.

Latency:
- start sampled at edge T0. PROC spans n clocks. done is high in the cycle after edge Tn.
- Start-to-done = n+1 clocks; the minimum is 1 clock, for n=0 or a length error.

Width rules:
- Accumulator is KW+2 bits signed, so magnitude 2^KW plus the sign fit without wrap.
- The range check uses the full accumulator.

Decomposition:
- Shared package naf_pkg holds:
  - Digit codes NAF_ZERO=2'b00, NAF_POS=2'b01, NAF_NEG=2'b11, NAF_BAD=2'b10.
  - Width constants KW/DW/LW.
  - One-hot state encodings, shared with the encoder.
  - err bit index constants.
- One sub-module, naf_digit_sel: combinational 2-bit selector over the latched DW vector by idx. It also provides the decoded signed digit and the illegal-code flag.

Test Plan:
- k=7: h[7:0]=8'b01_00_00_11 (digits -1,0,0,+1), rest 0, hlength=4 → done 5 clocks after start, k=7, err=0, busy high 4 cycles.
- hlength=0, any h → done 1 clock after start, k=0, err=0.
- Max length: h[1:0]=01, h[511:510]=01, others 0, hlength=256 → done at 257 clocks, k=2^255+1, err=0.
- Illegal inputs:
  - h[1:0]=10, hlength=1 → err=3'b001, k=0.
  - h[3:0]=4'b0101, hlength=2 → err=3'b010, k=0.
  - h[1:0]=11, hlength=1 (value -1) → err=3'b100, k=0.
  - hlength=300 → err=3'b100, done after 1 clock.
- Reset and control:
  - Assert rst at cycle 3 of the k=7 decode → no done pulse, k=0, err=0, IDLE.
  - A new start then decodes correctly.
  - A start pulse during PROC is ignored.
- Round-trip: 1000 random 255-bit k through the NAF encoder into naf_decode → recovered k equals the original, err=0.

Source files
------------

// File: rtl/naf_pkg.sv
// Shared constants and types for the NAF encoder/decoder pair.
// Digit codes, widths, FSM encodings and error bit positions live here.
package naf_pkg;

  localparam int unsigned KW = 256;
  localparam int unsigned DW = 2 * KW;
  localparam int unsigned LW = 32;
  localparam int unsigned IW = $clog2(KW);
  localparam int unsigned AW = KW + 2;
  localparam int unsigned EW = 3;

  localparam logic [1:0] NAF_ZERO = 2'b00;
  localparam logic [1:0] NAF_POS  = 2'b01;
  localparam logic [1:0] NAF_NEG  = 2'b11;
  localparam logic [1:0] NAF_BAD  = 2'b10;

  localparam int unsigned ERR_BAD = 0;
  localparam int unsigned ERR_ADJ = 1;
  localparam int unsigned ERR_RNG = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_PROC = 3'b010,
    ST_FIN  = 3'b100
  } naf_state_e;

endpackage

// File: rtl/naf_digit_sel.sv
// Picks digit idx out of the latched NAF vector and decodes it to a signed value.
// Illegal code 10 is flagged and decoded as zero.
module naf_digit_sel
  import naf_pkg::*;
(
  input  logic              [DW-1:0] i_h,
  input  logic              [IW-1:0] i_idx,
  output logic signed       [1:0]    o_digit_c,
  output logic                       o_bad_c
);

  logic [1:0] w_code;

  always_comb begin
    w_code    = i_h[{i_idx, 1'b0} +: 2];
    o_digit_c = 2'sd0;
    o_bad_c   = 1'b0;
    case (w_code)
      NAF_POS: o_digit_c = 2'sd1;
      NAF_NEG: o_digit_c = -2'sd1;
      NAF_BAD: o_bad_c   = 1'b1;
      default: o_digit_c = 2'sd0;
    endcase
  end

endmodule

// File: rtl/naf_decode.sv
// Rebuilds a KW-bit scalar from its NAF digit vector, one digit per clock, MSB first.
// k and err are updated only when leaving FIN and hold until the next accepted start.
module naf_decode
  import naf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] h,
  input  logic [LW-1:0] hlength,
  output logic [KW-1:0] k,
  output logic          busy,
  output logic          done,
  output logic [EW-1:0] err
);

  naf_state_e r_state;
  naf_state_e w_state_nx;

  logic        [DW-1:0] r_h;
  logic        [IW-1:0] r_idx;
  logic signed [AW-1:0] r_acc;
  logic                 r_prev_nz;
  logic        [EW-1:0] r_err_acc;
  logic        [KW-1:0] r_k;
  logic        [EW-1:0] r_err;
  logic                 r_busy;
  logic                 r_done;

  logic signed [1:0]    w_digit;
  logic                 w_bad;
  logic                 w_nz;
  logic                 w_len_zero;
  logic                 w_len_big;
  logic        [EW-1:0] w_err_init;
  logic        [EW-1:0] w_err_step;
  logic        [EW-1:0] w_err_fin;
  logic signed [AW-1:0] w_digit_ext;

  naf_digit_sel u_sel (
    .i_h       (r_h),
    .i_idx     (r_idx),
    .o_digit_c (w_digit),
    .o_bad_c   (w_bad)
  );

  always_comb begin
    w_len_zero  = (hlength == '0);
    w_len_big   = (hlength > LW'(KW));
    w_nz        = (w_digit != 2'sd0);
    w_digit_ext = $signed({{KW{w_digit[1]}}, w_digit});

    w_err_init          = '0;
    w_err_init[ERR_RNG] = w_len_big;

    w_err_step          = r_err_acc;
    w_err_step[ERR_BAD] = r_err_acc[ERR_BAD] | w_bad;
    w_err_step[ERR_ADJ] = r_err_acc[ERR_ADJ] | (w_nz & r_prev_nz);

    // Negative sets the sign bit; >= 2^KW sets bit KW or KW+1.
    w_err_fin          = r_err_acc;
    w_err_fin[ERR_RNG] = r_err_acc[ERR_RNG] | r_acc[AW-1] | r_acc[KW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nx = (w_len_zero || w_len_big) ? ST_FIN : ST_PROC;
      ST_PROC: if (r_idx == '0) w_state_nx = ST_FIN;
      ST_FIN:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h       <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_prev_nz <= 1'b0;
      r_err_acc <= '0;
      r_k       <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_state_nx == ST_PROC);
      r_done <= (w_state_nx == ST_FIN);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_h       <= h;
            r_idx     <= IW'(hlength - LW'(1));
            r_acc     <= '0;
            r_prev_nz <= 1'b0;
            r_err_acc <= w_err_init;
          end
        end
        ST_PROC: begin
          r_acc     <= (r_acc <<< 1) + w_digit_ext;
          r_prev_nz <= w_nz;
          r_idx     <= r_idx - IW'(1);
          r_err_acc <= w_err_step;
        end
        ST_FIN: begin
          r_err <= w_err_fin;
          r_k   <= (w_err_fin != '0) ? '0 : r_acc[KW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign k    = r_k;
  assign err  = r_err;
  assign busy = r_busy;
  assign done = r_done;

endmodule
